// File: rtl/rf_wb_queue.sv
// Write-back queue and read bypass in front of a 2R1W register file.
// Sweeps the file to zero after reset, then drains queued writes through the single write port.
module rf_wb_queue #(
    parameter int WSIZE   = 32,
    parameter int RCOUNT  = 32,
    parameter int R0_ZERO = 1,
    parameter int DEPTH   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [4:0]       WR_ADDR,
    input  logic [WSIZE-1:0] WR_DATA,
    input  logic             RF_HOLD,
    output logic             RF_WE,
    output logic [4:0]       RF_RW,
    output logic [WSIZE-1:0] RF_DW,
    input  logic [4:0]       RA,
    input  logic [4:0]       RB,
    input  logic [WSIZE-1:0] RF_DA,
    input  logic [WSIZE-1:0] RF_DB,
    output logic [WSIZE-1:0] DA,
    output logic [WSIZE-1:0] DB,
    output logic             BUSY,
    output logic             EMPTY
);
    // state | meaning
    // INIT  | zero sweep of the register file, one index per unheld cycle
    // RUN   | accept, queue and drain writes; bypass reads from the queue

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         PW1     = PW + 1;
    localparam logic [4:0] START   = (R0_ZERO != 0) ? 5'd1 : 5'd0;
    localparam logic [4:0] LAST    = 5'(RCOUNT - 1);
    localparam logic [PW:0] FULLCNT = PW1'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [4:0]        sweep;
    logic              busy_q;

    logic [4:0]        q_addr [DEPTH];
    logic [WSIZE-1:0]  q_data [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW:0]       count;

    logic              running;
    logic              full;
    logic              push;
    logic              pop;

    assign running = (state == RUN);
    assign full    = (count == FULLCNT);
    // Writes to a hard-wired zero register complete the handshake but never enter the queue.
    assign push    = running & WR_VALID & ~full & ~((R0_ZERO != 0) && (WR_ADDR == 5'd0));
    assign pop     = running & (count != '0) & ~RF_HOLD;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= INIT;
            sweep  <= START;
            busy_q <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    if (!RF_HOLD) begin
                        sweep <= sweep + 5'd1;
                        if (sweep == LAST) begin
                            state  <= RUN;
                            busy_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state  <= INIT;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_addr[tail] <= WR_ADDR;
            q_data[tail] <= WR_DATA;
        end
    end

    always_comb begin
        logic [PW-1:0] p;
        WR_READY = 1'b0;
        RF_WE    = 1'b0;
        RF_RW    = q_addr[head];
        RF_DW    = q_data[head];
        DA       = '0;
        DB       = '0;
        p        = head;
        if (state == INIT) begin
            RF_WE = ~RF_HOLD;
            RF_RW = sweep;
            RF_DW = '0;
        end else begin
            WR_READY = ~full;
            RF_WE    = (count != '0) & ~RF_HOLD;
            DA       = RF_DA;
            DB       = RF_DB;
            // Walk oldest to youngest so the last match wins.
            for (int i = 0; i < DEPTH; i++) begin
                p = head + PW'(i);
                if (PW1'(i) < count) begin
                    if (q_addr[p] == RA) DA = q_data[p];
                    if (q_addr[p] == RB) DB = q_data[p];
                end
            end
            if ((R0_ZERO != 0) && (RA == 5'd0)) DA = '0;
            if ((R0_ZERO != 0) && (RB == 5'd0)) DB = '0;
        end
    end

    assign BUSY  = busy_q;
    assign EMPTY = (count == '0);

endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: a queue-based model of pending writes predicts
// the write port, handshake and bypassed read data each cycle.
module tb_rf_wb_queue;
    localparam int WSIZE   = 32;
    localparam int RCOUNT  = 32;
    localparam int R0_ZERO = 1;
    localparam int DEPTH   = 2;
    localparam int START   = 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             WR_VALID = 1'b0;
    logic             WR_READY;
    logic [4:0]       WR_ADDR = '0;
    logic [WSIZE-1:0] WR_DATA = '0;
    logic             RF_HOLD = 1'b0;
    logic             RF_WE;
    logic [4:0]       RF_RW;
    logic [WSIZE-1:0] RF_DW;
    logic [4:0]       RA = '0;
    logic [4:0]       RB = '0;
    logic [WSIZE-1:0] RF_DA = '0;
    logic [WSIZE-1:0] RF_DB = '0;
    logic [WSIZE-1:0] DA;
    logic [WSIZE-1:0] DB;
    logic             BUSY;
    logic             EMPTY;

    rf_wb_queue #(.WSIZE(WSIZE), .RCOUNT(RCOUNT), .R0_ZERO(R0_ZERO), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .RF_HOLD(RF_HOLD), .RF_WE(RF_WE),
        .RF_RW(RF_RW), .RF_DW(RF_DW), .RA(RA), .RB(RB), .RF_DA(RF_DA), .RF_DB(RF_DB),
        .DA(DA), .DB(DB), .BUSY(BUSY), .EMPTY(EMPTY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]       a;
        logic [WSIZE-1:0] d;
    } wr_t;

    wr_t pend[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    bit  m_run  = 0;
    int  m_cnt  = START;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WSIZE-1:0] mread(input logic [4:0] idx, input logic [WSIZE-1:0] raw);
        logic [WSIZE-1:0] r;
        r = raw;
        if (R0_ZERO != 0 && idx == 5'd0) return '0;
        foreach (pend[i]) if (pend[i].a == idx) r = pend[i].d;
        return r;
    endfunction

    // Monitor and model: inputs are stable between the falling edge and the next rising edge.
    always @(negedge CLK) begin
        bit rdy_e, we_e;
        wr_t w;
        if (RST) begin
            m_run = 0;
            m_cnt = START;
            pend.delete();
            chk("rst_busy", 64'(BUSY), 64'd1);
            chk("rst_empty", 64'(EMPTY), 64'd1);
            chk("rst_ready", 64'(WR_READY), 64'd0);
            chk("rst_we", 64'(RF_WE), 64'(!RF_HOLD));
            chk("rst_rw", 64'(RF_RW), 64'(START));
            chk("rst_da", 64'(DA), 64'd0);
        end else if (!m_run) begin
            chk("init_busy", 64'(BUSY), 64'd1);
            chk("init_ready", 64'(WR_READY), 64'd0);
            chk("init_empty", 64'(EMPTY), 64'd1);
            chk("init_we", 64'(RF_WE), 64'(!RF_HOLD));
            chk("init_rw", 64'(RF_RW), 64'(m_cnt));
            chk("init_dw", 64'(RF_DW), 64'd0);
            chk("init_da", 64'(DA), 64'd0);
            chk("init_db", 64'(DB), 64'd0);
            if (!RF_HOLD) begin
                if (m_cnt == RCOUNT - 1) m_run = 1;
                m_cnt++;
            end
        end else begin
            rdy_e = (pend.size() < DEPTH);
            we_e  = (pend.size() > 0) && !RF_HOLD;
            chk("run_busy", 64'(BUSY), 64'd0);
            chk("run_ready", 64'(WR_READY), 64'(rdy_e));
            chk("run_empty", 64'(EMPTY), 64'(pend.size() == 0));
            chk("run_we", 64'(RF_WE), 64'(we_e));
            if (we_e) begin
                chk("run_rw", 64'(RF_RW), 64'(pend[0].a));
                chk("run_dw", 64'(RF_DW), 64'(pend[0].d));
            end
            chk("bypass_da", 64'(DA), 64'(mread(RA, RF_DA)));
            chk("bypass_db", 64'(DB), 64'(mread(RB, RF_DB)));
            if (we_e) void'(pend.pop_front());
            if (WR_VALID && rdy_e && !(R0_ZERO != 0 && WR_ADDR == 5'd0)) begin
                w.a = WR_ADDR;
                w.d = WR_DATA;
                pend.push_back(w);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_run();
        int n = 0;
        while (BUSY && n < 200) begin
            cyc();
            n++;
        end
        n_chk++;
        if (BUSY) begin
            n_fail++;
            $display("FAIL wait_run: BUSY still %0d after %0d cycles", BUSY, n);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [WSIZE-1:0] d);
        WR_VALID = 1'b1;
        WR_ADDR  = a;
        WR_DATA  = d;
    endtask

    initial begin
        cyc(2);
        RST = 1'b0;
        wait_run();
        cyc();

        // Back-to-back writes with no hold.
        wr(5'd5, 32'hA5A5A5A5); cyc();
        wr(5'd6, 32'h12345678); RA = 5'd5; RB = 5'd6; cyc();
        WR_VALID = 1'b0; cyc(3);

        // Hold: offer three writes, only two fit.
        RF_HOLD = 1'b1;
        wr(5'd9, 32'h11111111); cyc();
        wr(5'd10, 32'h22222222); cyc();
        wr(5'd11, 32'h33333333); cyc(2);
        WR_VALID = 1'b0;
        RF_HOLD  = 1'b0; cyc(4);

        // Youngest-match bypass with both entries for index 7 queued.
        RF_HOLD = 1'b1;
        RA = 5'd7; RB = 5'd7; RF_DA = 32'hDEAD; RF_DB = 32'hDEAD;
        wr(5'd7, 32'h1); cyc();
        wr(5'd7, 32'h2); cyc();
        WR_VALID = 1'b0; cyc(2);
        n_chk++;
        if (DA !== 32'h2 || DB !== 32'h2) begin
            n_fail++;
            $display("FAIL youngest: DA %0h DB %0h expected 2", DA, DB);
        end
        RF_HOLD = 1'b0; cyc(3);

        // Write to register zero is dropped.
        RA = 5'd0;
        wr(5'd0, 32'hFFFFFFFF); cyc();
        WR_VALID = 1'b0; cyc(2);

        // Reset mid-operation with two queued writes.
        RF_HOLD = 1'b1;
        wr(5'd3, 32'h33); cyc();
        wr(5'd4, 32'h44); cyc();
        WR_VALID = 1'b0; cyc();
        RST = 1'b1;
        #1;
        chk("midrst_empty", 64'(EMPTY), 64'd1);
        chk("midrst_busy", 64'(BUSY), 64'd1);
        cyc();
        RST = 1'b0;
        RF_HOLD = 1'b0;
        wait_run();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            WR_VALID = ($urandom_range(0, 3) != 0);
            WR_ADDR  = 5'($urandom_range(0, 7));
            WR_DATA  = $urandom;
            RF_HOLD  = ($urandom_range(0, 2) == 0);
            RA       = 5'($urandom_range(0, 7));
            RB       = 5'($urandom_range(0, 7));
            RF_DA    = $urandom;
            RF_DB    = $urandom;
            RST      = ($urandom_range(0, 499) == 0);
            cyc();
            RST = 1'b0;
        end
        WR_VALID = 1'b0;
        RF_HOLD  = 1'b0;
        cyc(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
